// File: rtl/trade_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trade_pkg
// Description : Shared types and widths for the order arbitration slice.
// Revision    : 1.0 - initial release
// ============================================================================
package trade_pkg;

    localparam int c_lot_w = 8;
    localparam int c_src_w = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        COOL  = 2'd2
    } state_e;

    typedef enum logic {
        SELL = 1'b0,
        BUY  = 1'b1
    } side_e;

endpackage
`default_nettype wire

// File: rtl/order_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : order_arbiter_if
// Description : Strategy request / order handshake bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface order_arbiter_if #(
    parameter int N_STRAT = 4
) ();

    logic [N_STRAT-1:0]               buy_req;
    logic [N_STRAT-1:0]               sell_req;
    logic                             order_ready;
    logic                             order_valid;
    logic                             order_side;
    logic [trade_pkg::c_src_w-1:0]    order_src;

    modport master (
        input  buy_req, sell_req, order_ready,
        output order_valid, order_side, order_src
    );

    modport slave (
        output buy_req, sell_req, order_ready,
        input  order_valid, order_side, order_src
    );

endinterface
`default_nettype wire

// File: rtl/order_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick: first request at or after ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 3
) (
    input  wire logic [N-1:0]     req,
    input  wire logic [IDX_W-1:0] ptr,
    output logic      [N-1:0]     grant,
    output logic      [IDX_W-1:0] idx,
    output logic                  any
);

    int w_slot;

    always_comb begin
        grant  = '0;
        idx    = '0;
        any    = 1'b0;
        w_slot = 0;
        for (int k = 0; k < N; k++) begin
            w_slot = int'(ptr) + k;
            if (w_slot >= N) begin
                w_slot = w_slot - N;
            end
            if (!any && req[w_slot]) begin
                any           = 1'b1;
                grant[w_slot] = 1'b1;
                idx           = IDX_W'(w_slot);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/order_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : order_arbiter
// Description : Round-robin strategy order arbiter with position limits.
// Revision    : 1.0 - initial release
// ============================================================================
module order_arbiter
    import trade_pkg::*;
#(
    parameter int         N_STRAT  = 4,
    parameter logic [7:0] MAX_POS  = 8'd8,
    parameter int         COOLDOWN = 4
) (
    input  wire logic                clk,
    input  wire logic                rst,
    order_arbiter_if.master          bus,
    output logic [c_lot_w-1:0]       position,
    output logic                     busy,
    output logic [7:0]               conflict_cnt
);

    localparam logic signed [c_lot_w-1:0] c_pos_hi    = $signed(MAX_POS);
    localparam logic signed [c_lot_w-1:0] c_pos_lo    = -$signed(MAX_POS);
    localparam logic [3:0]                c_cool_load = (COOLDOWN > 0) ? 4'(COOLDOWN - 1) : 4'd0;
    localparam logic [c_src_w-1:0]        c_last_src  = c_src_w'(N_STRAT - 1);

    state_e                      r_state;
    logic                        r_order_valid;
    side_e                       r_order_side;
    logic [c_src_w-1:0]          r_order_src;
    logic [c_src_w-1:0]          r_rr_ptr;
    logic signed [c_lot_w-1:0]   r_position;
    logic [7:0]                  r_conflict_cnt;
    logic [3:0]                  r_cool_cnt;
    logic                        r_busy;

    logic [N_STRAT-1:0]          w_buy_ok;
    logic [N_STRAT-1:0]          w_sell_ok;
    logic [N_STRAT-1:0]          w_grant;
    logic [c_src_w-1:0]          w_grant_idx;
    logic                        w_grant_any;
    logic                        w_conflict;

    // A strategy asserting both sides is ineligible and only bumps the counter.
    assign w_conflict = |(bus.buy_req & bus.sell_req);
    assign w_buy_ok   = bus.buy_req & ~bus.sell_req & {N_STRAT{r_position < c_pos_hi}};
    assign w_sell_ok  = bus.sell_req & ~bus.buy_req & {N_STRAT{r_position > c_pos_lo}};

    rr_arbiter #(
        .N     (N_STRAT),
        .IDX_W (c_src_w)
    ) u_rr (
        .req   (w_buy_ok | w_sell_ok),
        .ptr   (r_rr_ptr),
        .grant (w_grant),
        .idx   (w_grant_idx),
        .any   (w_grant_any)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_order_valid  <= 1'b0;
            r_order_side   <= SELL;
            r_order_src    <= '0;
            r_rr_ptr       <= '0;
            r_position     <= '0;
            r_conflict_cnt <= '0;
            r_cool_cnt     <= '0;
            r_busy         <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_conflict && (r_conflict_cnt != 8'hFF)) begin
                        r_conflict_cnt <= r_conflict_cnt + 8'd1;
                    end
                    if (w_grant_any) begin
                        r_state       <= ISSUE;
                        r_order_valid <= 1'b1;
                        r_order_side  <= (|(w_grant & w_buy_ok)) ? BUY : SELL;
                        r_order_src   <= w_grant_idx;
                        r_busy        <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (bus.order_ready) begin
                        r_order_valid <= 1'b0;
                        r_position    <= (r_order_side == BUY) ? r_position + 8'sd1
                                                               : r_position - 8'sd1;
                        r_rr_ptr      <= (r_order_src == c_last_src) ? '0 : r_order_src + 3'd1;
                        if (COOLDOWN > 0) begin
                            r_state    <= COOL;
                            r_cool_cnt <= c_cool_load;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                COOL: begin
                    if (r_cool_cnt == 4'd0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cool_cnt <= r_cool_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    r_order_valid <= 1'b0;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.order_valid = r_order_valid;
    assign bus.order_side  = r_order_side;
    assign bus.order_src   = r_order_src;
    assign position        = r_position;
    assign busy            = r_busy;
    assign conflict_cnt    = r_conflict_cnt;

endmodule
`default_nettype wire

// File: tb/tb_order_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_order_arbiter
// Description : Self-checking bench for order_arbiter against a cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_order_arbiter;
    import trade_pkg::*;

    localparam int N    = 4;
    localparam int CD   = 4;
    localparam int MAXP = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] position;
    logic [7:0] conflict_cnt;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: pending order, cooldown cycles left, position etc.
    int m_valid, m_side, m_src, m_pos, m_conf, m_ptr, m_cool;

    int         r30_src[$];
    int         r30_rise[$];
    int         r30_fall[$];
    logic       r30_prev;
    logic [N-1:0] rb, rs;

    always #5 clk = ~clk;

    order_arbiter_if #(.N_STRAT(N)) bus ();

    order_arbiter #(
        .N_STRAT  (N),
        .MAX_POS  (8'(MAXP)),
        .COOLDOWN (CD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .position     (position),
        .busy         (busy),
        .conflict_cnt (conflict_cnt)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_side = 0; m_src = 0; m_pos = 0;
        m_conf  = 0; m_ptr  = 0; m_cool = 0;
    endtask

    task automatic model_step(input logic [N-1:0] b, input logic [N-1:0] s, input logic r);
        if (m_valid != 0) begin
            if (r) begin
                m_pos   = m_pos + ((m_side != 0) ? 1 : -1);
                m_ptr   = (m_src + 1) % N;
                m_valid = 0;
                m_cool  = CD;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else begin
            if ((b & s) != '0) m_conf = (m_conf < 255) ? m_conf + 1 : 255;
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (m_valid == 0 && (b[i] ^ s[i]) &&
                    (b[i] ? (m_pos < MAXP) : (m_pos > -MAXP))) begin
                    m_valid = 1;
                    m_side  = int'(b[i]);
                    m_src   = i;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".valid"}, int'(bus.order_valid), m_valid);
        check_eq({tag, ".side"},  int'(bus.order_side), m_side);
        check_eq({tag, ".src"},   int'(bus.order_src), m_src);
        check_eq({tag, ".pos"},   int'($signed(position)), m_pos);
        check_eq({tag, ".busy"},  int'(busy), (m_valid != 0 || m_cool > 0) ? 1 : 0);
        check_eq({tag, ".conf"},  int'(conflict_cnt), m_conf);
    endtask

    task automatic cycle(input logic [N-1:0] b, input logic [N-1:0] s, input logic r,
                         input string tag);
        @(negedge clk);
        bus.buy_req     = b;
        bus.sell_req    = s;
        bus.order_ready = r;
        model_step(b, s, r);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst             = 1'b0;
        bus.buy_req     = '0;
        bus.sell_req    = '0;
        bus.order_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check_all("reset");
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst             = 1'b0;
        bus.buy_req     = '0;
        bus.sell_req    = '0;
        bus.order_ready = 1'b0;
        model_reset();

        // First order after reset: one-cycle latency, then 4 cooldown cycles
        do_reset();
        cycle(4'b0001, 4'b0000, 1'b1, "r29g");
        check_eq("r29.valid", int'(bus.order_valid), 1);
        check_eq("r29.side",  int'(bus.order_side), 1);
        check_eq("r29.src",   int'(bus.order_src), 0);
        cycle(4'b0000, 4'b0000, 1'b1, "r29f");
        check_eq("r29.pos", int'($signed(position)), 1);
        check_eq("r29.busy0", int'(busy), 1);
        for (int c = 0; c < 3; c++) begin
            cycle(4'b0000, 4'b0000, 1'b1, "r29c");
            check_eq("r29.busy", int'(busy), 1);
        end
        cycle(4'b0000, 4'b0000, 1'b1, "r29e");
        check_eq("r29.idle", int'(busy), 0);

        // All strategies buying: strict rotation with fixed spacing
        do_reset();
        r30_prev = 1'b0;
        for (int c = 0; c < 40; c++) begin
            cycle(4'b1111, 4'b0000, 1'b1, "r30");
            if (bus.order_valid && !r30_prev) begin
                r30_src.push_back(int'(bus.order_src));
                r30_rise.push_back(c);
            end
            if (!bus.order_valid && r30_prev) r30_fall.push_back(c);
            r30_prev = bus.order_valid;
        end
        check_eq("r30.count", (r30_src.size() >= 5) ? 1 : 0, 1);
        for (int k = 0; k < 5 && k < r30_src.size(); k++)
            check_eq("r30.src", r30_src[k], k % N);
        for (int k = 0; k < 4 && k + 1 < r30_rise.size() && k < r30_fall.size(); k++)
            check_eq("r30.gap", r30_rise[k + 1] - r30_fall[k], CD + 1);

        // Buy and sell from the same strategy: counted, never granted
        do_reset();
        repeat (3) cycle(4'b0001, 4'b0001, 1'b1, "r32");
        check_eq("r32.conf",  int'(conflict_cnt), 3);
        check_eq("r32.valid", int'(bus.order_valid), 0);

        // Backpressure: order held stable while ready is low
        do_reset();
        cycle(4'b0000, 4'b0100, 1'b0, "r33g");
        for (int c = 0; c < 10; c++) begin
            rb = N'($urandom);
            rs = N'($urandom);
            cycle(rb, rs, 1'b0, "r33h");
            check_eq("r33.valid", int'(bus.order_valid), 1);
            check_eq("r33.side",  int'(bus.order_side), 0);
            check_eq("r33.src",   int'(bus.order_src), 2);
            check_eq("r33.pos",   int'($signed(position)), 0);
        end
        cycle(4'b0000, 4'b0000, 1'b1, "r33f");
        check_eq("r33.posf", int'($signed(position)), -1);

        // Long position limit: buys blocked, sells still allowed
        do_reset();
        for (int c = 0; c < 200 && !(m_pos == MAXP && m_valid == 0 && m_cool == 0); c++)
            cycle(4'b0001, 4'b0000, 1'b1, "r31fill");
        check_eq("r31.full", int'($signed(position)), MAXP);
        for (int c = 0; c < 8; c++) begin
            cycle(4'b1111, 4'b0000, 1'b1, "r31blk");
            check_eq("r31.nobuy", int'(bus.order_valid), 0);
        end
        cycle(4'b0010, 4'b0100, 1'b0, "r31g");
        check_eq("r31.valid", int'(bus.order_valid), 1);
        check_eq("r31.side",  int'(bus.order_side), 0);
        check_eq("r31.src",   int'(bus.order_src), 2);
        cycle(4'b0000, 4'b0000, 1'b1, "r31f");
        check_eq("r31.pos", int'($signed(position)), MAXP - 1);

        // Asynchronous reset while an order is pending
        do_reset();
        cycle(4'b0001, 4'b0000, 1'b0, "r34g");
        cycle(4'b0000, 4'b0000, 1'b0, "r34h");
        check_eq("r34.pend", int'(bus.order_valid), 1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_eq("r34.valid", int'(bus.order_valid), 0);
        check_all("r34");
        @(negedge clk);
        rst = 1'b1;
        model_step(4'b0000, 4'b0000, 1'b0);
        cycle(4'b0001, 4'b0000, 1'b1, "r34n");
        check_eq("r34.regrant", int'(bus.order_valid), 1);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rb = N'($urandom) & N'($urandom);
            rs = N'($urandom) & N'($urandom);
            cycle(rb, rs, ($urandom_range(0, 3) != 0), "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
